// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter slice.
package dmem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } arb_state_e;

    typedef enum logic {
        REQ_CORE,
        REQ_HOST
    } req_id_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection for the dmem arbiter.
// Define DMEM_ARB_RR_EN for round-robin; default is core priority with a host starvation guard.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int HOST_MAX_WAIT = 8,
    parameter int CNT_W         = 4
) (
    input  logic             core_req,
    input  logic             host_req,
    input  logic             core_mask,
    input  logic             host_mask,
`ifdef DMEM_ARB_RR_EN
    input  req_id_e          last_grant,
`else
    input  logic [CNT_W-1:0] starve_cnt,
`endif
    output logic             grant_valid,
    output req_id_e          grant_id
);

    logic core_elig;
    logic host_elig;

    // The requester being acked this cycle is not eligible again until the next cycle.
    assign core_elig = core_req && !core_mask;
    assign host_elig = host_req && !host_mask;

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        grant_valid = core_elig || host_elig;
        grant_id    = REQ_CORE;
        if (core_elig && host_elig) begin
            grant_id = (last_grant == REQ_CORE) ? REQ_HOST : REQ_CORE;
        end else if (host_elig) begin
            grant_id = REQ_HOST;
        end
    end
`else
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(HOST_MAX_WAIT);

    logic force_host;

    assign force_host = (HOST_MAX_WAIT != 0) && (starve_cnt == STARVE_MAX);

    always_comb begin
        grant_valid = core_elig || host_elig;
        grant_id    = REQ_CORE;
        if (host_elig && (!core_elig || force_host)) begin
            grant_id = REQ_HOST;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core and a host loader/debug port.
// Optional macro DMEM_ARB_RR_EN selects round-robin arbitration instead of core priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_LAT       = 1,
    parameter int HOST_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_wr,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_ack,
    input  logic              host_req,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_data_out,
    output logic              dmem_wr,
    input  logic [DATA_W-1:0] dmem_data_in
);

    localparam int          CNT_W     = (HOST_MAX_WAIT < 1) ? 1 : $clog2(HOST_MAX_WAIT + 1);
    localparam logic [1:0]  WAIT_LOAD = 2'(MEM_LAT - 1);

    arb_state_e        state;
    arb_state_e        state_next;
    req_id_e           grant_id;
    logic              grant_wr;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;
    logic [1:0]        wait_cnt;
    logic              arbitrate;
    logic              core_mask;
    logic              host_mask;
    logic              pick_valid;
    req_id_e           pick_id;

    assign arbitrate = (state == IDLE) || (state == RESP);
    assign core_mask = (state == RESP) && (grant_id == REQ_CORE);
    assign host_mask = (state == RESP) && (grant_id == REQ_HOST);

`ifdef DMEM_ARB_RR_EN
    req_id_e last_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= REQ_CORE;
        end else if (arbitrate && pick_valid) begin
            last_grant <= pick_id;
        end
    end
`else
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(HOST_MAX_WAIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             host_elig;

    assign host_elig = host_req && !host_mask;

    // Counts arbitration rounds the host loses; saturates so the guard stays armed.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (arbitrate) begin
            if (!host_elig || (pick_valid && pick_id == REQ_HOST)) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`endif

    dmem_arb_pick #(
        .HOST_MAX_WAIT (HOST_MAX_WAIT),
        .CNT_W         (CNT_W)
    ) u_pick (
        .core_req    (core_req),
        .host_req    (host_req),
        .core_mask   (core_mask),
        .host_mask   (host_mask),
`ifdef DMEM_ARB_RR_EN
        .last_grant  (last_grant),
`else
        .starve_cnt  (starve_cnt),
`endif
        .grant_valid (pick_valid),
        .grant_id    (pick_id)
    );

    always_comb begin
        state_next    = state;
        dmem_wr       = 1'b0;
        dmem_addr     = '0;
        dmem_data_out = '0;
        core_ack      = 1'b0;
        host_ack      = 1'b0;
        case (state)
            IDLE:   state_next = pick_valid ? ACCESS : IDLE;
            ACCESS: begin
                state_next    = grant_wr ? RESP : WAIT;
                dmem_wr       = grant_wr;
                dmem_addr     = grant_addr;
                dmem_data_out = grant_wdata;
            end
            WAIT:   state_next = (wait_cnt == 2'd0) ? RESP : WAIT;
            RESP: begin
                state_next = pick_valid ? ACCESS : IDLE;
                core_ack   = (grant_id == REQ_CORE);
                host_ack   = (grant_id == REQ_HOST);
            end
            default: state_next = IDLE;
        endcase
    end

    // Grant capture, latency countdown and read-data return.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant_id    <= REQ_CORE;
            grant_wr    <= 1'b0;
            grant_addr  <= '0;
            grant_wdata <= '0;
            wait_cnt    <= 2'd0;
            core_rdata  <= '0;
            host_rdata  <= '0;
        end else begin
            state <= state_next;
            if (arbitrate && pick_valid) begin
                grant_id    <= pick_id;
                grant_wr    <= (pick_id == REQ_HOST) ? host_wr    : core_wr;
                grant_addr  <= (pick_id == REQ_HOST) ? host_addr  : core_addr;
                grant_wdata <= (pick_id == REQ_HOST) ? host_wdata : core_wdata;
            end
            if (state == ACCESS) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == WAIT && wait_cnt != 2'd0) begin
                wait_cnt <= wait_cnt - 2'd1;
            end
            if (state == WAIT && wait_cnt == 2'd0) begin
                if (grant_id == REQ_CORE) begin
                    core_rdata <= dmem_data_in;
                end else begin
                    host_rdata <= dmem_data_in;
                end
            end
        end
    end

endmodule
